obi_burst_bridge: RTL and testbench

- Parametrised successor of the single-instruction host-to-X-HEEP bridge.
- Accepts queued host commands (single or burst, read or write) from the CW305 USB register side through a command FIFO.
- Issues them as OBI master transactions into gr_heep_top.
- Returns read data through a response FIFO, so the host can stream memory loads and dumps without per-word handshaking.

---
 rtl/obi_burst_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_obi_burst_bridge.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_burst_bridge.sv
// Host command FIFO -> single-outstanding OBI master; read data returns via response FIFO. Cmd to req in 2 cycles, >=2 cycles/beat,
// reads stall while the response FIFO is full, cmd_ready_o = !full. Define OBI_BRIDGE_STATS_EN for saturating beat/stall counters.

module obi_burst_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & !empty;
  // A push into a full FIFO lands only if the head leaves in the same cycle.
  assign do_push = push & (!full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push != do_pop) level <= do_push ? level + LW'(1) : level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module obi_burst_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int RSP_DEPTH  = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic                           cmd_we_i,
  input  logic [DATA_WIDTH/8-1:0]        cmd_be_i,
  input  logic [ADDR_WIDTH-1:0]          cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]          cmd_wdata_i,
  input  logic [LEN_WIDTH-1:0]           cmd_len_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [DATA_WIDTH-1:0]          rsp_rdata_o,
  output logic                           req_o,
  output logic                           we_o,
  output logic [DATA_WIDTH/8-1:0]        be_o,
  output logic [ADDR_WIDTH-1:0]          addr_o,
  output logic [DATA_WIDTH-1:0]          wdata_o,
  input  logic                           gnt_i,
  input  logic                           rvalid_i,
  input  logic [DATA_WIDTH-1:0]          rdata_i,
  output logic                           busy_o,
  output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_level_o,
  output logic [$clog2(RSP_DEPTH+1)-1:0] rsp_level_o,
  output logic [31:0]                    beat_cnt_o,
  output logic [31:0]                    stall_cnt_o
);
  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BE_W);

  typedef struct packed {
    logic                  we;
    logic [BE_W-1:0]       be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [LEN_WIDTH-1:0]  len;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t state, state_next;
  cmd_t   cmd_in, cmd_head, work;
  logic   cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic   rsp_push, rsp_full, rsp_empty;
  logic   req, beat_done;

  assign cmd_in      = {cmd_we_i, cmd_be_i, cmd_addr_i, cmd_wdata_i, cmd_len_i};
  assign cmd_ready_o = !cmd_full;
  assign cmd_push    = cmd_valid_i & !cmd_full;

  obi_burst_bridge_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_push),
    .wdata (cmd_in),
    .pop   (cmd_pop),
    .rdata (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .level (cmd_level_o)
  );

  assign rsp_push    = beat_done & !work.we;
  assign rsp_valid_o = !rsp_empty;

  obi_burst_bridge_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_push),
    .wdata (rdata_i),
    .pop   (rsp_ready_i),
    .rdata (rsp_rdata_o),
    .full  (rsp_full),
    .empty (rsp_empty),
    .level (rsp_level_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cmd_pop    = 1'b0;
    req        = 1'b0;
    beat_done  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!cmd_empty) begin
          cmd_pop    = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        // Only one read is ever in flight, so a free slot now stays free until its rvalid.
        req = work.we | !rsp_full;
        if (req && gnt_i) state_next = WAIT_R;
      end
      WAIT_R: begin
        if (rvalid_i) begin
          beat_done  = 1'b1;
          state_next = (work.len != '0) ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // work.len doubles as the remaining-beat count of the active command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
    end else if (cmd_pop) begin
      work <= cmd_head;
    end else if (beat_done && work.len != '0) begin
      work.addr <= work.addr + ADDR_STEP;
      work.len  <= work.len - LEN_WIDTH'(1);
    end
  end

  assign req_o   = req;
  assign we_o    = work.we;
  assign be_o    = work.be;
  assign addr_o  = work.addr;
  assign wdata_o = work.wdata;
  assign busy_o  = (state != IDLE) | !cmd_empty;

`ifdef OBI_BRIDGE_STATS_EN
  logic [31:0] beat_cnt, stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (beat_done && beat_cnt != '1)          beat_cnt  <= beat_cnt + 32'd1;
      if (req && !gnt_i && stall_cnt != '1)     stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign beat_cnt_o  = beat_cnt;
  assign stall_cnt_o = stall_cnt;
`else
  assign beat_cnt_o  = '0;
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_obi_burst_bridge.sv
// Randomised bench for obi_burst_bridge: OBI slave with memory, host popper, and a command-level
// reference model that expands each accepted command into expected beats and expected read data.
module tb_obi_burst_bridge;
  logic        clk, rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [3:0]  cmd_be_i, cmd_len_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        req_o, we_o, gnt_i, rvalid_i, busy_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o, wdata_o, rdata_i, beat_cnt_o, stall_cnt_o;
  logic [2:0]  cmd_level_o, rsp_level_o;

  obi_burst_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_be_i(cmd_be_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_len_i(cmd_len_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .busy_o(busy_o), .cmd_level_o(cmd_level_o), .rsp_level_o(rsp_level_o),
    .beat_cnt_o(beat_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } beat_t;

  int checks = 0;
  int errors = 0;

  beat_t       exp_beats[$];
  logic [31:0] exp_rsp[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];

  int          gnt_pct = 100, rv_min = 0, rv_max = 0, pop_pct = 100;
  bit          spur = 1'b0;
  bit          pend = 1'b0;
  int          pend_wait = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] last_addr = '0;
  int          beat_model = 0, stall_model = 0;
  beat_t       sl_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Reference model: a command is a run of len+1 word beats from addr, applied in order.
  task automatic model_accept(input logic we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] len);
    logic [31:0] a, cur;
    for (int i = 0; i <= int'(len); i++) begin
      a   = addr + 32'(4 * i);
      cur = model_mem.exists(a) ? model_mem[a] : dflt(a);
      exp_beats.push_back({we, be, a, wdata});
      if (we) model_mem[a] = merge(cur, wdata, be);
      else    exp_rsp.push_back(cur);
    end
  endtask

  task automatic push_cmd(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] len);
    int n;
    n = 0;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_be_i = be;
    cmd_addr_i = addr; cmd_wdata_i = wdata; cmd_len_i = len;
    while (!cmd_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", cmd_ready_o, 1);
    if (cmd_ready_o) begin
      model_accept(we, be, addr, wdata, len);
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((busy_o || pend || rsp_valid_o || exp_beats.size() != 0 || exp_rsp.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_dut"}, {busy_o, rsp_valid_o}, 0);
    check({tag, "_model"}, 32'(exp_beats.size() + exp_rsp.size()), 0);
  endtask

  // OBI slave: grants, memory, response delay, and spurious gnt/rvalid while they must be ignored.
  initial begin
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gnt_i = 1'b0; rvalid_i = 1'b0; pend = 1'b0;
        beat_model = 0; stall_model = 0;
      end else begin
        gnt_i = 1'b0; rvalid_i = 1'b0;
        if (pend) begin
          if (pend_wait == 0) begin
            rvalid_i = 1'b1; rdata_i = pend_data; pend = 1'b0; beat_model++;
          end else pend_wait--;
        end else if (spur && $urandom_range(0, 3) == 0) begin
          rvalid_i = 1'b1; rdata_i = $urandom;
        end
        if (req_o) begin
          if ($urandom_range(0, 99) < gnt_pct) begin
            gnt_i = 1'b1;
            last_addr = addr_o;
            if (exp_beats.size() == 0) check("beat_extra", addr_o, 32'hxxxx_xxxx);
            else begin
              sl_e = exp_beats.pop_front();
              check("beat_we", we_o, sl_e.we);
              check("beat_be", be_o, sl_e.be);
              check("beat_addr", addr_o, sl_e.addr);
              if (sl_e.we) check("beat_wdata", wdata_o, sl_e.wdata);
            end
            if (we_o) begin
              slave_mem[addr_o] = merge(slave_mem.exists(addr_o) ? slave_mem[addr_o] : dflt(addr_o), wdata_o, be_o);
              pend_data = $urandom;
            end else pend_data = slave_mem.exists(addr_o) ? slave_mem[addr_o] : dflt(addr_o);
            pend = 1'b1;
            pend_wait = $urandom_range(rv_min, rv_max);
          end else stall_model++;
        end else if (spur && $urandom_range(0, 3) == 0) gnt_i = 1'b1;
      end
    end
  end

  // Host side: pops responses at a random rate and checks them in order.
  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) rsp_ready_i = 1'b0;
      else begin
        rsp_ready_i = ($urandom_range(0, 99) < pop_pct);
        if (rsp_ready_i && rsp_valid_o) begin
          if (exp_rsp.size() == 0) check("rsp_extra", rsp_rdata_o, 32'hxxxx_xxxx);
          else check("rsp_data", rsp_rdata_o, exp_rsp.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    int n;
    rst_n = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_be_i = '0;
    cmd_addr_i = '0; cmd_wdata_i = '0; cmd_len_i = '0;
    repeat (3) @(negedge clk);
    check("rst_req", req_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_cmd_level", cmd_level_o, 0);
    check("rst_rsp_level", rsp_level_o, 0);
    check("rst_addr", addr_o, 0);
    check("rst_beat_cnt", beat_cnt_o, 0);
    check("rst_stall_cnt", stall_cnt_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write: accepted in N, req at N+2 with the exact fields.
    push_cmd(1'b1, 4'hF, 32'h0000_1000, 32'hCAFE_BABE, 4'd0);
    check("wr_n1_req", req_o, 0);
    check("wr_n1_busy", busy_o, 1);
    @(negedge clk);
    check("wr_n2_req", req_o, 1);
    check("wr_n2_we", we_o, 1);
    check("wr_n2_addr", addr_o, 32'h0000_1000);
    check("wr_n2_wdata", wdata_o, 32'hCAFE_BABE);
    check("wr_n2_be", be_o, 4'hF);
    wait_drain("wr_drain");
    check("wr_rsp_level", rsp_level_o, 0);

    // Read burst from preloaded words; first word at the response head at N+4.
    for (int i = 0; i < 4; i++) begin
      ra = 32'h2000 + 32'(4 * i);
      slave_mem[ra] = 32'(8'h11 * (i + 1));
      model_mem[ra] = 32'(8'h11 * (i + 1));
    end
    pop_pct = 0;
    push_cmd(1'b0, 4'hF, 32'h0000_2000, 32'h0, 4'd3);
    repeat (2) @(negedge clk);
    check("rd_n3_rsp_valid", rsp_valid_o, 0);
    @(negedge clk);
    check("rd_n4_rsp_valid", rsp_valid_o, 1);
    check("rd_n4_rsp_data", rsp_rdata_o, 32'h11);
    pop_pct = 100;
    wait_drain("rd_drain");

    // Backpressure: response FIFO fills at 4 and the bridge stops requesting.
    pop_pct = 0;
    push_cmd(1'b0, 4'hF, 32'h0000_3000, 32'h0, 4'd7);
    repeat (40) @(negedge clk);
    check("bp_rsp_level", rsp_level_o, 4);
    check("bp_req_low", req_o, 0);
    check("bp_busy", busy_o, 1);
    pop_pct = 100;
    wait_drain("bp_drain");
    check("bp_level_end", rsp_level_o, 0);

    // Command FIFO full while the slave withholds grant.
    gnt_pct = 0;
    for (int i = 0; i < 5; i++) push_cmd(1'b1, 4'hF, 32'h4000 + 32'(4 * i), 32'hA0 + 32'(i), 4'd0);
    check("full_cmd_level", cmd_level_o, 4);
    check("full_cmd_ready", cmd_ready_o, 0);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_be_i = 4'hF;
    cmd_addr_i = 32'h4100; cmd_wdata_i = 32'hB0; cmd_len_i = 4'd0;
    repeat (5) @(negedge clk);
    check("full_held_ready", cmd_ready_o, 0);
    check("full_held_level", cmd_level_o, 4);
    check("full_req_stable", req_o, 1);
    check("full_addr_stable", addr_o, 32'h4000);
    check("full_wdata_stable", wdata_o, 32'hA0);
    gnt_pct = 100;
    push_cmd(1'b1, 4'hF, 32'h0000_4100, 32'hB0, 4'd0);
    wait_drain("full_drain");

    // Address wrap at the top of the space.
    push_cmd(1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0, 4'd1);
    wait_drain("wrap_drain");
    check("wrap_addr", last_addr, 32'h0000_0000);

    // Random traffic with random grant/response/pop timing.
    spur = 1'b1;
    for (int k = 0; k < 40; k++) begin
      gnt_pct = $urandom_range(30, 100);
      rv_max  = $urandom_range(0, 3);
      pop_pct = $urandom_range(20, 100);
      ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3))
                                       : 32'h8000 + 32'(4 * $urandom_range(0, 31));
      push_cmd(1'($urandom), 4'($urandom_range(1, 15)), ra, $urandom, 4'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    pop_pct = 100;
    wait_drain("rand_drain");
`ifdef OBI_BRIDGE_STATS_EN
    check("stat_beats", beat_cnt_o, 32'(beat_model));
    check("stat_stalls", stall_cnt_o, 32'(stall_model));
`else
    check("stat_beats_off", beat_cnt_o, 0);
    check("stat_stalls_off", stall_cnt_o, 0);
`endif

    // Reset in WAIT_R of the second beat of a read burst, with one word held in the response FIFO.
    spur = 1'b0; pop_pct = 0; gnt_pct = 100; rv_min = 4; rv_max = 4;
    push_cmd(1'b0, 4'hF, 32'h0000_5000, 32'h0, 4'd3);
    n = 0;
    while (!(rsp_valid_o && pend) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_setup", rsp_valid_o, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", req_o, 0);
    check("mid_rst_rsp_valid", rsp_valid_o, 0);
    check("mid_rst_cmd_level", cmd_level_o, 0);
    check("mid_rst_rsp_level", rsp_level_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_beat_cnt", beat_cnt_o, 0);
    repeat (2) @(negedge clk);
    exp_beats.delete();
    exp_rsp.delete();
    rst_n = 1'b1;
    rv_min = 0; rv_max = 0; pop_pct = 100;
    @(negedge clk);
    push_cmd(1'b0, 4'hF, 32'h0000_2000, 32'h0, 4'd0);
    wait_drain("post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
